coo_matrix_loader: RTL and testbench
====================================

Name: coo_matrix_loader

Overview:
- Upstream stage of the COO row fetcher.
- Accepts a serial stream of COO triples (value, row, col), one per valid/ready beat.
- Assembles them into parallel IN_SIZE-entry data/row/col tables.
- Presents the complete matrix with a valid/ready handshake, holding it stable until the consumer has fetched all rows it needs.

Parameters:
- IN_SIZE, 4, number of table entries (max non-zeros per matrix).
- DATA_WIDTH, 16, width of each value.
- ADDR_WIDTH, 16, width of each row/col index.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  DATA_WIDTH  value of incoming triple.
- in_row  input  ADDR_WIDTH  row index of incoming triple.
- in_col  input  ADDR_WIDTH  column index of incoming triple.
- in_last  input  1  marks final triple of the current matrix; qualified by in_valid.
- in_valid  input  1  triple on in_* is valid.
- in_ready  output  1  loader accepts a triple this cycle.
- out_data  output  DATA_WIDTH x IN_SIZE  value table.
- out_row_table  output  ADDR_WIDTH x IN_SIZE  row table.
- out_col_table  output  ADDR_WIDTH x IN_SIZE  column table.
- out_count  output  $clog2(IN_SIZE+1)  number of valid entries in the presented matrix.
- out_valid  output  1  tables hold a complete matrix.
- out_ready  input  1  consumer releases the matrix.
- order_err  output  1  sticky ordering-violation flag (see Optional Feature).

Behaviour:
- States: FILL and PRESENT.
- Reset (synchronous, overrides everything, including mid-fill or mid-present):
  - state=FILL, write pointer=0, out_count=0, out_valid=0, in_ready=1, order_err=0.
  - Every entry: out_data=0, out_row_table=all-ones, out_col_table=0.
  - Any partial matrix is discarded.
- Row padding: unused entries always hold row = all-ones (2^ADDR_WIDTH-1), so a downstream fetch for row 0 never matches padding. Row index all-ones is reserved and never sent by producers.
- FILL state:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: write triple at entry[wr_ptr]; wr_ptr and out_count increment by 1.
  - Leave FILL when the accepted beat has in_last=1, or when it is the IN_SIZE-th beat (implicit last; in_last on that beat is redundant and harmless).
  - Transition to PRESENT takes effect the next cycle. out_valid rises one cycle after the final beat is accepted, and tables are already updated on that cycle.
- PRESENT state:
  - in_ready=0, out_valid=1; tables and out_count held constant.
  - On out_valid&&out_ready: next cycle state=FILL, wr_ptr=0, out_count=0, all entries re-cleared to padding values, in_ready=1.
  - No triple is accepted in the handoff cycle, so there is a minimum one-cycle bubble between matrices.
- in_ready is a registered state decode; no combinational path from out_ready to in_ready.
- An empty matrix is impossible: a matrix always has at least one beat, because in_last only counts with in_valid.
- Producer holding in_valid while in_ready=0: no state change; the triple stays pending until FILL.

Optional Feature:
- Macro: COO_LOADER_ORDER_CHECK_EN.
- Defined:
  - Each accepted beat after the first of a matrix is compared with the previous accepted triple.
  - order_err is set (sticky until rst) if in_row < prev row, or if in_row == prev row and in_col <= prev col. This enforces strict row-major order with no duplicates.
  - Data is still stored normally; the error does not block flow.
- Undefined: no comparison logic is built; order_err is tied to 0.

Test Plan:
- Reset, then 4 beats (1,r0,c0)(2,r0,c2)(3,r1,c1)(4,r2,c3) with in_last=0 → out_valid=1 one cycle after 4th beat, out_count=4, tables match, in_ready=0.
- 2 beats (7,r3,c0)(9,r3,c1), last on 2nd → out_count=2; entries 2,3 have data=0, row=0xFFFF, col=0.
- PRESENT with out_ready low for 10 cycles while in_valid high → tables stable, no beat consumed. Assert out_ready → next cycle in_ready=1, out_count=0, all entries at padding.
- Assert rst after 2 of 3 beats → next cycle out_count=0, padding restored. Then a fresh 1-beat matrix with last → out_count=1.
- Back-to-back matrices with in_valid held high → exactly one-cycle in_ready gap after the release handshake; no beat lost or duplicated.
- With COO_LOADER_ORDER_CHECK_EN, beats (r1,c2)(r1,c2) → order_err=1 after 2nd beat, stays 1 through next matrix until rst. Without the macro → order_err=0.

Source files
------------

// File: rtl/coo_matrix_loader_if.sv
// -----------------------------------------------------------------------------
// coo_matrix_loader_if
//
// Purpose: bundles the producer-side triple stream and the consumer-side
// matrix handshake of the COO matrix loader into one interface.
//
// Signals:
//   in_data / in_row / in_col  incoming COO triple (value, row, col)
//   in_last                    final triple of the current matrix (with in_valid)
//   in_valid / in_ready        producer handshake
//   out_data                   IN_SIZE x DATA_WIDTH value table (entry 0 in LSBs)
//   out_row_table              IN_SIZE x ADDR_WIDTH row table
//   out_col_table              IN_SIZE x ADDR_WIDTH column table
//   out_count                  number of valid entries in the presented matrix
//   out_valid / out_ready      consumer handshake (out_ready releases the matrix)
//   order_err                  sticky ordering-violation flag
//
// Modports:
//   slave  - the loader itself
//   master - the environment driving triples and consuming matrices
// -----------------------------------------------------------------------------
interface coo_matrix_loader_if #(
    parameter int IN_SIZE    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    localparam int CW = $clog2(IN_SIZE + 1);

    logic [DATA_WIDTH-1:0]                 in_data;
    logic [ADDR_WIDTH-1:0]                 in_row;
    logic [ADDR_WIDTH-1:0]                 in_col;
    logic                                  in_last;
    logic                                  in_valid;
    logic                                  in_ready;
    logic [IN_SIZE-1:0][DATA_WIDTH-1:0]    out_data;
    logic [IN_SIZE-1:0][ADDR_WIDTH-1:0]    out_row_table;
    logic [IN_SIZE-1:0][ADDR_WIDTH-1:0]    out_col_table;
    logic [CW-1:0]                         out_count;
    logic                                  out_valid;
    logic                                  out_ready;
    logic                                  order_err;

    modport slave (
        input  in_data, in_row, in_col, in_last, in_valid, out_ready,
        output in_ready, out_data, out_row_table, out_col_table,
               out_count, out_valid, order_err
    );

    modport master (
        output in_data, in_row, in_col, in_last, in_valid, out_ready,
        input  in_ready, out_data, out_row_table, out_col_table,
               out_count, out_valid, order_err
    );
endinterface

// File: rtl/coo_matrix_loader.sv
// -----------------------------------------------------------------------------
// coo_matrix_loader
//
// Purpose: upstream stage of the COO row fetcher. Collects a serial stream of
// COO triples (value, row, col) into parallel IN_SIZE-entry tables and
// presents the finished matrix with a valid/ready handshake, holding it
// stable until the consumer releases it.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset (clears everything, drops any partial
//         matrix)
//   bus   coo_matrix_loader_if.slave: triple input stream, matrix output
//         tables, out_count, handshakes and order_err
//
// Optional feature (compile-time macro COO_LOADER_ORDER_CHECK_EN):
//   when defined, every accepted beat after the first of a matrix is checked
//   for strict row-major order against the previous beat; a violation sets
//   the sticky order_err flag (cleared only by rst). When undefined no
//   comparison logic exists and order_err is tied low.
//
// Unused table entries always hold row = all-ones so a downstream search for
// any real row (including 0) never hits padding; producers never send the
// all-ones row index.
// -----------------------------------------------------------------------------
module coo_matrix_loader #(
    parameter int IN_SIZE    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    coo_matrix_loader_if.slave   bus
);
    localparam int CW = $clog2(IN_SIZE + 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_PAD = '1;

    typedef enum logic {
        FILL    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    state_e                              state_q;
    logic [CW-1:0]                       count_q;
    logic [CW-1:0]                       count_d;
    logic [IN_SIZE-1:0][DATA_WIDTH-1:0]  data_q;
    logic [IN_SIZE-1:0][ADDR_WIDTH-1:0]  row_q;
    logic [IN_SIZE-1:0][ADDR_WIDTH-1:0]  col_q;
    logic                                in_ready_q;
    logic                                out_valid_q;
    logic                                accept_d;
    logic                                last_beat_d;

    // in_ready_q is 1 exactly in FILL, so it doubles as the acceptance qualifier.
    always_comb begin
        accept_d    = bus.in_valid && in_ready_q;
        count_d     = count_q + CW'(1);
        // The IN_SIZE-th beat closes the matrix even without in_last.
        last_beat_d = bus.in_last || (count_q == CW'(IN_SIZE - 1));
    end

`ifdef COO_LOADER_ORDER_CHECK_EN
    logic [ADDR_WIDTH-1:0] prev_row_q;
    logic [ADDR_WIDTH-1:0] prev_col_q;
    logic                  order_err_q;
    logic                  order_viol_d;

    // The first beat of a matrix (count 0) has no predecessor to compare with.
    always_comb begin
        order_viol_d = accept_d && (count_q != '0) &&
                       ((bus.in_row < prev_row_q) ||
                        ((bus.in_row == prev_row_q) && (bus.in_col <= prev_col_q)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_row_q  <= '0;
            prev_col_q  <= '0;
            order_err_q <= 1'b0;
        end else begin
            if (accept_d) begin
                prev_row_q <= bus.in_row;
                prev_col_q <= bus.in_col;
            end
            if (order_viol_d) begin
                order_err_q <= 1'b1;
            end
        end
    end

    assign bus.order_err = order_err_q;
`else
    assign bus.order_err = 1'b0;
`endif

    // Main FSM: state, pointer, tables and handshake outputs are all registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            for (int i = 0; i < IN_SIZE; i++) begin
                data_q[i] <= '0;
                row_q[i]  <= ROW_PAD;
                col_q[i]  <= '0;
            end
        end else begin
            case (state_q)
                FILL: begin
                    if (accept_d) begin
                        for (int i = 0; i < IN_SIZE; i++) begin
                            if (count_q == CW'(i)) begin
                                data_q[i] <= bus.in_data;
                                row_q[i]  <= bus.in_row;
                                col_q[i]  <= bus.in_col;
                            end
                        end
                        count_q <= count_d;
                        if (last_beat_d) begin
                            state_q     <= PRESENT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    // Release cycle: nothing is accepted here, giving the
                    // one-cycle bubble before the next matrix.
                    if (bus.out_ready) begin
                        state_q     <= FILL;
                        count_q     <= '0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        for (int i = 0; i < IN_SIZE; i++) begin
                            data_q[i] <= '0;
                            row_q[i]  <= ROW_PAD;
                            col_q[i]  <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= FILL;
                end
            endcase
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_count     = count_q;
    assign bus.out_data      = data_q;
    assign bus.out_row_table = row_q;
    assign bus.out_col_table = col_q;

endmodule

// File: tb/tb_coo_matrix_loader.sv
// -----------------------------------------------------------------------------
// tb_coo_matrix_loader
//
// Directed bench for coo_matrix_loader (IN_SIZE=4, 16-bit data/indices).
// Tables are compared as whole packed vectors, entry 0 in the low 16 bits.
// -----------------------------------------------------------------------------
module tb_coo_matrix_loader;
    localparam int IN_SIZE    = 4;
    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    coo_matrix_loader_if #(
        .IN_SIZE   (IN_SIZE),
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) bus ();

    coo_matrix_loader #(
        .IN_SIZE   (IN_SIZE),
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Present one beat and hold it until accepted (bounded), then drop valid.
    task automatic send(input logic [15:0] d, input logic [15:0] r,
                        input logic [15:0] c, input logic last);
        int n;
        bus.in_data  = d;
        bus.in_row   = r;
        bus.in_col   = c;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) chk("send_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic release_matrix();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic chk_padding(input string tag);
        chk({tag, "_count"}, 64'(bus.out_count), 64'd0);
        chk({tag, "_data"},  bus.out_data,        64'h0);
        chk({tag, "_rows"},  bus.out_row_table,   64'hFFFF_FFFF_FFFF_FFFF);
        chk({tag, "_cols"},  bus.out_col_table,   64'h0);
        chk({tag, "_ready"}, 64'(bus.in_ready),   64'd1);
        chk({tag, "_valid"}, 64'(bus.out_valid),  64'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_data   = '0;
        bus.in_row    = '0;
        bus.in_col    = '0;
        bus.in_last   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk_padding("rst");
        chk("rst_err", 64'(bus.order_err), 64'd0);

        // Full matrix, implicit last on the 4th beat
        send(16'd1, 16'd0, 16'd0, 1'b0);
        send(16'd2, 16'd0, 16'd2, 1'b0);
        send(16'd3, 16'd1, 16'd1, 1'b0);
        chk("m1_valid_early", 64'(bus.out_valid), 64'd0);
        chk("m1_count3",      64'(bus.out_count), 64'd3);
        send(16'd4, 16'd2, 16'd3, 1'b0);
        chk("m1_valid", 64'(bus.out_valid),  64'd1);
        chk("m1_ready", 64'(bus.in_ready),   64'd0);
        chk("m1_count", 64'(bus.out_count),  64'd4);
        chk("m1_data",  bus.out_data,        64'h0004_0003_0002_0001);
        chk("m1_rows",  bus.out_row_table,   64'h0002_0001_0000_0000);
        chk("m1_cols",  bus.out_col_table,   64'h0003_0001_0002_0000);
        release_matrix();
        chk_padding("rel1");

        // Short matrix, explicit last on the 2nd beat
        send(16'd7, 16'd3, 16'd0, 1'b0);
        send(16'd9, 16'd3, 16'd1, 1'b1);
        chk("m2_valid", 64'(bus.out_valid),  64'd1);
        chk("m2_count", 64'(bus.out_count),  64'd2);
        chk("m2_data",  bus.out_data,        64'h0000_0000_0009_0007);
        chk("m2_rows",  bus.out_row_table,   64'hFFFF_FFFF_0003_0003);
        chk("m2_cols",  bus.out_col_table,   64'h0000_0000_0001_0000);

        // Hold in PRESENT with a pending beat; nothing may be consumed
        bus.in_data  = 16'd5;
        bus.in_row   = 16'd4;
        bus.in_col   = 16'd0;
        bus.in_last  = 1'b1;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("hold_ready", 64'(bus.in_ready), 64'd0);
        end
        chk("hold_count", 64'(bus.out_count),  64'd2);
        chk("hold_data",  bus.out_data,        64'h0000_0000_0009_0007);
        chk("hold_rows",  bus.out_row_table,   64'hFFFF_FFFF_0003_0003);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        release_matrix();
        chk_padding("rel2");

        // Reset in the middle of a fill discards the partial matrix
        send(16'd1, 16'd5, 16'd0, 1'b0);
        send(16'd2, 16'd5, 16'd1, 1'b0);
        chk("mid_count", 64'(bus.out_count), 64'd2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_padding("midrst");
        send(16'd8, 16'd6, 16'd6, 1'b1);
        chk("m3_count", 64'(bus.out_count),  64'd1);
        chk("m3_valid", 64'(bus.out_valid),  64'd1);
        chk("m3_data",  bus.out_data,        64'h0000_0000_0000_0008);
        chk("m3_rows",  bus.out_row_table,   64'hFFFF_FFFF_FFFF_0006);
        chk("m3_cols",  bus.out_col_table,   64'h0000_0000_0000_0006);
        release_matrix();

        // Back-to-back matrices with in_valid and out_ready held high
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data = 16'd11; bus.in_row = 16'd7; bus.in_col = 16'd0; bus.in_last = 1'b0;
        @(posedge clk);
        #1;
        bus.in_data = 16'd12; bus.in_row = 16'd7; bus.in_col = 16'd1; bus.in_last = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_a_valid", 64'(bus.out_valid), 64'd1);
        chk("b2b_a_count", 64'(bus.out_count), 64'd2);
        chk("b2b_a_data",  bus.out_data,       64'h0000_0000_000C_000B);
        chk("b2b_gap",     64'(bus.in_ready),  64'd0);
        bus.in_data = 16'd13; bus.in_row = 16'd8; bus.in_col = 16'd0; bus.in_last = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_reopen",  64'(bus.in_ready),  64'd1);
        chk("b2b_empty",   64'(bus.out_count), 64'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("b2b_b_valid", 64'(bus.out_valid),     64'd1);
        chk("b2b_b_count", 64'(bus.out_count),     64'd1);
        chk("b2b_b_data",  bus.out_data,           64'h0000_0000_0000_000D);
        chk("b2b_b_rows",  bus.out_row_table,      64'hFFFF_FFFF_FFFF_0008);
        chk("b2b_err",     64'(bus.order_err),     64'd0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk_padding("b2b_rel");

        // Duplicate coordinate: ordering violation
        send(16'd1, 16'd1, 16'd2, 1'b0);
        send(16'd2, 16'd1, 16'd2, 1'b1);
        chk("dup_count", 64'(bus.out_count), 64'd2);
        chk("dup_data",  bus.out_data,       64'h0000_0000_0002_0001);
`ifdef COO_LOADER_ORDER_CHECK_EN
        chk("dup_err", 64'(bus.order_err), 64'd1);
`else
        chk("dup_err", 64'(bus.order_err), 64'd0);
`endif
        release_matrix();
        send(16'd3, 16'd0, 16'd0, 1'b1);
`ifdef COO_LOADER_ORDER_CHECK_EN
        chk("err_sticky", 64'(bus.order_err), 64'd1);
`else
        chk("err_sticky", 64'(bus.order_err), 64'd0);
`endif
        chk("m5_count", 64'(bus.out_count), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("err_cleared", 64'(bus.order_err), 64'd0);
        chk_padding("final_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
